// File: rtl/bp_fe_queue_rolly_multi.sv
// rtl/bp_fe_queue_rolly_multi.sv - speculative-replay FE->BE queue with multi-entry commit, roll and clear
// Optional same-cycle bypass into an empty queue: define BP_FE_QUEUE_BYPASS_EN.
module bp_fe_queue_rolly_multi #(
    parameter  int width_p          = 128,
    parameter  int els_p            = 8,
    parameter  int deq_max_p        = 2,
    localparam int ptr_width_lp     = $clog2(els_p) + 1,
    localparam int cnt_width_lp     = $clog2(els_p + 1),
    localparam int deq_cnt_width_lp = $clog2(deq_max_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [width_p-1:0]          data_i,
    input  logic                        v_i,
    output logic                        ready_o,

    output logic [width_p-1:0]          data_o,
    output logic                        v_o,
    input  logic                        yumi_i,

    input  logic                        deq_v_i,
    input  logic [deq_cnt_width_lp-1:0] deq_cnt_i,
    input  logic                        roll_v_i,
    input  logic                        clr_v_i,

    output logic [cnt_width_lp-1:0]     spec_cnt_o,
    output logic [cnt_width_lp-1:0]     unread_cnt_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;
    localparam int cmp_width_lp = (deq_cnt_width_lp > ptr_width_lp) ? deq_cnt_width_lp : ptr_width_lp;

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] cptr_q, cptr_d;

    logic [width_p-1:0] mem_q [els_p];

    // Differences are taken at pointer width so the wrap bit folds them modulo 2*els_p.
    logic [ptr_width_lp-1:0] spec_diff;
    logic [ptr_width_lp-1:0] unread_diff;
    logic [ptr_width_lp-1:0] avail_diff;

    assign spec_diff   = wptr_q - cptr_q;
    assign unread_diff = wptr_q - rptr_q;
    assign avail_diff  = rptr_q - cptr_q;

    assign spec_cnt_o   = cnt_width_lp'(spec_diff);
    assign unread_cnt_o = cnt_width_lp'(unread_diff);
    assign ready_o      = (spec_diff != ptr_width_lp'(els_p));

    logic we;
    logic bypass;

    assign we = v_i & ready_o & ~clr_v_i;

`ifdef BP_FE_QUEUE_BYPASS_EN
    assign bypass = (unread_diff == '0) & we;
`else
    assign bypass = 1'b0;
`endif

    assign v_o    = (unread_diff != '0) | bypass;
    assign data_o = bypass ? data_i : mem_q[rptr_q[idx_width_lp-1:0]];

    logic [cmp_width_lp-1:0] req_ext;
    logic [cmp_width_lp-1:0] avail_ext;
    logic [cmp_width_lp-1:0] commit_ext;
    logic [ptr_width_lp-1:0] commit_cnt;

    // Commit saturates at the number of entries already read.
    always_comb begin
        req_ext    = cmp_width_lp'(deq_cnt_i);
        avail_ext  = cmp_width_lp'(avail_diff);
        commit_ext = (req_ext < avail_ext) ? req_ext : avail_ext;
        commit_cnt = ptr_width_lp'(commit_ext);
    end

    always_comb begin
        cptr_d = cptr_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;

        if (deq_v_i) begin
            cptr_d = cptr_q + commit_cnt;
        end

        if (roll_v_i) begin
            rptr_d = cptr_d;
        end else if (yumi_i && v_o) begin
            rptr_d = rptr_q + 1'b1;
        end

        // Clear trims the write pointer back to the (possibly rolled) read point.
        if (clr_v_i) begin
            wptr_d = rptr_d;
        end else if (we) begin
            wptr_d = wptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
        end
    end

endmodule

// File: tb/tb_bp_fe_queue_rolly_multi.sv
// tb/tb_bp_fe_queue_rolly_multi.sv - directed vector bench for bp_fe_queue_rolly_multi
module tb_bp_fe_queue_rolly_multi;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [127:0] data_i;
    logic         v_i;
    logic         ready_o;
    logic [127:0] data_o;
    logic         v_o;
    logic         yumi_i;
    logic         deq_v_i;
    logic [1:0]   deq_cnt_i;
    logic         roll_v_i;
    logic         clr_v_i;
    logic [3:0]   spec_cnt_o;
    logic [3:0]   unread_cnt_o;

    bp_fe_queue_rolly_multi #(.width_p(128), .els_p(8), .deq_max_p(2)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .deq_v_i      (deq_v_i),
        .deq_cnt_i    (deq_cnt_i),
        .roll_v_i     (roll_v_i),
        .clr_v_i      (clr_v_i),
        .spec_cnt_o   (spec_cnt_o),
        .unread_cnt_o (unread_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        yumi;
        logic        deq_v;
        logic [1:0]  deq_cnt;
        logic        roll;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic        erdy;
        logic [3:0]  espec;
        logic [3:0]  eunr;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(logic v, logic [31:0] d, logic yumi, logic deq_v, logic [1:0] deq_cnt,
                                logic roll, logic clr, logic ev, logic [31:0] ed, logic erdy,
                                logic [3:0] espec, logic [3:0] eunr);
        vec_t r;
        r.v = v; r.d = d; r.yumi = yumi; r.deq_v = deq_v; r.deq_cnt = deq_cnt;
        r.roll = roll; r.clr = clr; r.ev = ev; r.ed = ed; r.erdy = erdy;
        r.espec = espec; r.eunr = eunr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        v_i = 1'b0; data_i = '0; yumi_i = 1'b0; deq_v_i = 1'b0;
        deq_cnt_i = 2'd0; roll_v_i = 1'b0; clr_v_i = 1'b0;
    endtask

    function automatic logic [127:0] wide(input logic [31:0] d);
        return {96'h0, d};
    endfunction

    initial begin
        int rd_idx;
        reset_n_i = 1'b0;
        idle_inputs();

        // Fill A0..A7, then a dropped write while full.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 32'hA0 + i, 0, 0, 0, 0, 0, 1, 32'hA0, (i < 7), 4'(i + 1), 4'(i + 1)));
        vecs.push_back(mk(1, 32'hDEAD, 0, 0, 0, 0, 0, 1, 32'hA0, 0, 8, 8));
        // Read 3, roll back.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hA1 + i, 0, 8, 4'(7 - i)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'hA0, 0, 8, 8));
        // Read 3, commit 2, commit 2 (saturates to 1).
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hA1 + i, 0, 8, 4'(7 - i)));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 1, 32'hA3, 1, 6, 5));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 1, 32'hA3, 1, 5, 5));
        // Two more reads so rptr - cptr = 2, then everything at once.
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hA4, 1, 5, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hA5, 1, 5, 3));
        vecs.push_back(mk(1, 32'hB0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0));
        // Refill one, read it with a zero-count commit, then saturating commit.
        vecs.push_back(mk(1, 32'hC0, 0, 0, 0, 0, 0, 1, 32'hC0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0));

        #12;
        chk("reset_v_o", v_o, 0);
        chk("reset_ready", ready_o, 1);
        chk("reset_spec", spec_cnt_o, 0);
        chk("reset_unread", unread_cnt_o, 0);
        reset_n_i = 1'b1;

        foreach (vecs[n]) begin
            v_i = vecs[n].v; data_i = wide(vecs[n].d); yumi_i = vecs[n].yumi;
            deq_v_i = vecs[n].deq_v; deq_cnt_i = vecs[n].deq_cnt;
            roll_v_i = vecs[n].roll; clr_v_i = vecs[n].clr;
            @(posedge clk_i);
            #1;
            idle_inputs();
            #1;
            chk($sformatf("vec%0d_v_o", n), v_o, vecs[n].ev);
            chk($sformatf("vec%0d_ready", n), ready_o, vecs[n].erdy);
            chk($sformatf("vec%0d_spec", n), spec_cnt_o, vecs[n].espec);
            chk($sformatf("vec%0d_unread", n), unread_cnt_o, vecs[n].eunr);
            if (vecs[n].ev)
                chk($sformatf("vec%0d_data", n), data_o, wide(vecs[n].ed));
        end

        // Stream 40 entries through with yumi + commit 1 each cycle.
        rd_idx = 0;
        for (int c = 0; c < 46; c++) begin
            v_i = (c < 40); data_i = wide(32'h5000 + c);
            deq_v_i = 1'b1; deq_cnt_i = 2'd1;
            #1;
            yumi_i = v_o;
            if (v_o) begin
                chk("wrap_data", data_o, wide(32'h5000 + rd_idx));
                rd_idx++;
            end
            chk("wrap_spec_le8", (spec_cnt_o <= 4'd8), 1);
            chk("wrap_unread_le_spec", (unread_cnt_o <= spec_cnt_o), 1);
            @(posedge clk_i);
            #1;
            idle_inputs();
        end
        chk("wrap_read_count", rd_idx, 40);
        chk("wrap_final_unread", unread_cnt_o, 0);
        chk("wrap_final_spec", spec_cnt_o, 0);

        // Queue 5 entries then reset between edges.
        for (int i = 0; i < 5; i++) begin
            v_i = 1'b1; data_i = wide(32'h7000 + i);
            @(posedge clk_i);
            #1;
        end
        idle_inputs();
        #1;
        chk("pre_areset_unread", unread_cnt_o, 5);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("areset_v_o", v_o, 0);
        chk("areset_ready", ready_o, 1);
        chk("areset_spec", spec_cnt_o, 0);
        chk("areset_unread", unread_cnt_o, 0);
        #1;
        reset_n_i = 1'b1;

        // Enqueue into the empty queue: same-cycle with bypass, next cycle without.
        @(posedge clk_i);
        #1;
        v_i = 1'b1; data_i = wide(32'hBEEF);
        #1;
`ifdef BP_FE_QUEUE_BYPASS_EN
        chk("bypass_v_o", v_o, 1);
        chk("bypass_data", data_o, wide(32'hBEEF));
`else
        chk("nobypass_v_o", v_o, 0);
`endif
        @(posedge clk_i);
        #1;
        idle_inputs();
        #1;
        chk("enq_v_o", v_o, 1);
        chk("enq_data", data_o, wide(32'hBEEF));
        chk("enq_unread", unread_cnt_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
